// File: rtl/mat_op_seq.sv
// Matrix operation sequencer: validates operand shapes, walks the result matrix
// row-major, issues operand reads, accumulates terms and writes result elements.
module mat_op_seq #(
  parameter int DW   = 8,
  parameter int MAXD = 5,
  parameter int AW   = 5,
  parameter int RW   = 2*DW+3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_op,
  input  logic [2:0]    op_sel,
  input  logic [2:0]    a_rows,
  input  logic [2:0]    a_cols,
  input  logic [2:0]    b_rows,
  input  logic [2:0]    b_cols,
  input  logic [DW-1:0] scalar,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  input  logic [DW-1:0] rd_data_a,
  input  logic [DW-1:0] rd_data_b,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [RW-1:0] wr_data,
  output logic [2:0]    res_rows,
  output logic [2:0]    res_cols,
  output logic          busy,
  output logic          done,
  output logic          error_flag
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SCL = 3'b010;
  localparam logic [2:0] OP_TRN = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [2:0] MAXD3 = 3'(MAXD);

  logic [2:0]           state_q, state_d, op_q, op_d;
  logic [2:0]           ar_q, ar_d, ac_q, ac_d, br_q, br_d, bc_q, bc_d;
  logic signed [DW-1:0] scalar_q, scalar_d;
  logic [2:0]           i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [RW-1:0] acc_q, acc_d, acc_sum;
  logic                 rd_vld_q, rd_vld_d;
  logic                 rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [AW-1:0]        rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic signed [RW-1:0] wr_data_q, wr_data_d;
  logic [2:0]           res_rows_q, res_rows_d, res_cols_q, res_cols_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 a_bad, b_bad, chk_err;
  logic [2:0]           kmax;

  function automatic logic [AW-1:0] addr_f(input logic [2:0] r, input logic [2:0] stride,
                                           input logic [2:0] c);
    return AW'(r) * AW'(stride) + AW'(c);
  endfunction

  // Every term is widened to the accumulator width before the arithmetic.
  function automatic logic signed [RW-1:0] term_f(input logic [2:0] op,
                                                  input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b,
                                                  input logic signed [DW-1:0] s);
    logic signed [RW-1:0] ae, be, se;
    ae = a;
    be = b;
    se = s;
    case (op)
      OP_ADD:  return ae + be;
      OP_SUB:  return ae - be;
      OP_SCL:  return ae * se;
      OP_TRN:  return ae;
      OP_MUL:  return ae * be;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    a_bad = (ar_q == 3'd0) || (ar_q > MAXD3) || (ac_q == 3'd0) || (ac_q > MAXD3);
    b_bad = (br_q == 3'd0) || (br_q > MAXD3) || (bc_q == 3'd0) || (bc_q > MAXD3);
    case (op_q)
      OP_ADD, OP_SUB: chk_err = a_bad || b_bad || (ar_q != br_q) || (ac_q != bc_q);
      OP_SCL, OP_TRN: chk_err = a_bad;
      OP_MUL:         chk_err = a_bad || b_bad || (ac_q != br_q);
      default:        chk_err = 1'b1;
    endcase
    kmax = (op_q == OP_MUL) ? ac_q - 3'd1 : 3'd0;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ar_d       = ar_q;
    ac_d       = ac_q;
    br_d       = br_q;
    bc_d       = bc_q;
    scalar_d   = scalar_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    rd_vld_d   = rd_en_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    res_rows_d = res_rows_q;
    res_cols_d = res_cols_q;
    err_d      = err_q;
    // Bank data arrives one cycle after each read strobe.
    acc_sum    = acc_q + term_f(op_q, rd_data_a, rd_data_b, scalar_q);
    acc_d      = rd_vld_q ? acc_sum : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start_op) begin
          op_d     = op_sel;
          ar_d     = a_rows;
          ac_d     = a_cols;
          br_d     = b_rows;
          bc_d     = b_cols;
          scalar_d = scalar;
          err_d    = 1'b0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        acc_d = '0;
        if (chk_err) begin
          state_d = S_ERR;
        end else begin
          state_d = S_READ;
          i_d = 3'd0;
          j_d = 3'd0;
          k_d = 3'd0;
          case (op_q)
            OP_TRN:  begin res_rows_d = ac_q; res_cols_d = ar_q; end
            OP_MUL:  begin res_rows_d = ar_q; res_cols_d = bc_q; end
            default: begin res_rows_d = ar_q; res_cols_d = ac_q; end
          endcase
        end
      end
      S_READ: begin
        if (k_q == kmax) state_d = S_DRAIN;
        else             k_d = k_q + 3'd1;
      end
      S_DRAIN: begin
        state_d   = S_WRITE;
        wr_en_d   = 1'b1;
        wr_addr_d = addr_f(i_q, res_cols_q, j_q);
        wr_data_d = acc_sum;
      end
      S_WRITE: begin
        acc_d = '0;
        k_d   = 3'd0;
        if (j_q == res_cols_q - 3'd1) begin
          j_d = 3'd0;
          i_d = i_q + 3'd1;
        end else begin
          j_d = j_q + 3'd1;
        end
        if ((i_q == res_rows_q - 3'd1) && (j_q == res_cols_q - 3'd1)) state_d = S_DONE;
        else                                                          state_d = S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state/counters.
    rd_en_d     = (state_d == S_READ);
    rd_addr_a_d = '0;
    rd_addr_b_d = '0;
    if (rd_en_d) begin
      case (op_q)
        OP_ADD, OP_SUB: begin
          rd_addr_a_d = addr_f(i_d, ac_q, j_d);
          rd_addr_b_d = addr_f(i_d, ac_q, j_d);
        end
        OP_SCL: rd_addr_a_d = addr_f(i_d, ac_q, j_d);
        OP_TRN: rd_addr_a_d = addr_f(j_d, ac_q, i_d);
        OP_MUL: begin
          rd_addr_a_d = addr_f(i_d, ac_q, k_d);
          rd_addr_b_d = addr_f(k_d, bc_q, j_d);
        end
        default: ;
      endcase
    end
    busy_d = (state_d == S_CHECK) || (state_d == S_READ) ||
             (state_d == S_DRAIN) || (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
    if (state_d == S_ERR) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      ar_q        <= '0;
      ac_q        <= '0;
      br_q        <= '0;
      bc_q        <= '0;
      scalar_q    <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      res_rows_q  <= '0;
      res_cols_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ar_q        <= ar_d;
      ac_q        <= ac_d;
      br_q        <= br_d;
      bc_q        <= bc_d;
      scalar_q    <= scalar_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      rd_vld_q    <= rd_vld_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      res_rows_q  <= res_rows_d;
      res_cols_q  <= res_cols_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr_a  = rd_addr_a_q;
  assign rd_addr_b  = rd_addr_b_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign res_rows   = res_rows_q;
  assign res_cols   = res_cols_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error_flag = err_q;

endmodule

// File: tb/tb_mat_op_seq.sv
// Bench for mat_op_seq: operand banks, a matrix-level reference model, and
// cycle-by-cycle checks of strobes, addresses, results and completion timing.
module tb_mat_op_seq;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int RW = 2*DW+3;

  logic          clk = 1'b0;
  logic          rst_n, start_op;
  logic [2:0]    op_sel, a_rows, a_cols, b_rows, b_cols;
  logic [DW-1:0] scalar;
  logic          rd_en, wr_en, busy, done, error_flag;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0] rd_data_a = '0;
  logic [DW-1:0] rd_data_b = '0;
  logic [RW-1:0] wr_data;
  logic [2:0]    res_rows, res_cols;

  int tests = 0;
  int fails = 0;
  logic signed [DW-1:0] mem_a [32];
  logic signed [DW-1:0] mem_b [32];
  int ra_q[$], rb_q[$], wd_q[$];
  int exp_rr, exp_rc, exp_k;
  bit exp_err, prev_err;

  always #5 clk = ~clk;

  mat_op_seq dut (
    .clk(clk), .rst_n(rst_n), .start_op(start_op), .op_sel(op_sel),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .scalar(scalar), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .res_rows(res_rows), .res_cols(res_cols), .busy(busy),
    .done(done), .error_flag(error_flag)
  );

  // Synchronous-read operand banks.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_data_b <= mem_b[rd_addr_b];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
              res_rows, res_cols, busy, done, error_flag}, 64'd0);
  endtask

  // Matrix-level reference: legality, result shape, read sequence, element values.
  task automatic model(input logic [2:0] op, ar, ac, br, bc, input logic [7:0] s);
    int sv, v, ia, ib;
    bit oka, okb;
    sv = int'($signed(s));
    ra_q.delete(); rb_q.delete(); wd_q.delete();
    oka = (ar >= 1) && (ar <= 5) && (ac >= 1) && (ac <= 5);
    okb = (br >= 1) && (br <= 5) && (bc >= 1) && (bc <= 5);
    case (op)
      3'd0, 3'd1: exp_err = !(oka && okb && ar == br && ac == bc);
      3'd2, 3'd3: exp_err = !oka;
      3'd4:       exp_err = !(oka && okb && ac == br);
      default:    exp_err = 1'b1;
    endcase
    exp_rr = (op == 3'd3) ? int'(ac) : int'(ar);
    exp_rc = (op == 3'd3) ? int'(ar) : (op == 3'd4) ? int'(bc) : int'(ac);
    exp_k  = (op == 3'd4) ? int'(ac) : 1;
    if (exp_err) return;
    for (int i = 0; i < exp_rr; i++) begin
      for (int j = 0; j < exp_rc; j++) begin
        v = 0;
        for (int k = 0; k < exp_k; k++) begin
          ib = 0;
          case (op)
            3'd0: begin ia = i*ac + j; ib = ia; v = mem_a[ia] + mem_b[ib]; end
            3'd1: begin ia = i*ac + j; ib = ia; v = mem_a[ia] - mem_b[ib]; end
            3'd2: begin ia = i*ac + j; v = mem_a[ia] * sv; end
            3'd3: begin ia = j*ac + i; v = mem_a[ia]; end
            default: begin ia = i*ac + k; ib = k*bc + j; v += mem_a[ia] * mem_b[ib]; end
          endcase
          ra_q.push_back(ia);
          rb_q.push_back(ib);
        end
        wd_q.push_back(v);
      end
    end
  endtask

  task automatic run(input logic [2:0] op, ar, ac, br, bc, input logic [7:0] s,
                     input int repulse, input int abort_cyc);
    int done_cyc, last, wcnt;
    bit aborted;
    model(op, ar, ac, br, bc, s);
    @(negedge clk);
    chk("err_hold", error_flag, prev_err);
    op_sel = op; a_rows = ar; a_cols = ac; b_rows = br; b_cols = bc; scalar = s;
    start_op = 1'b1;
    @(posedge clk);
    done_cyc = exp_err ? 0 : 2 + exp_rr*exp_rc*(exp_k+2);
    last = exp_err ? 5 : done_cyc + 2;
    wcnt = 0;
    aborted = 1'b0;
    for (int cyc = 1; cyc <= last && !aborted; cyc++) begin
      @(negedge clk);
      start_op = (cyc == repulse);
      if (cyc == repulse) begin
        op_sel = 3'($urandom); a_rows = 3'($urandom); a_cols = 3'($urandom);
        b_rows = 3'($urandom); b_cols = 3'($urandom); scalar = 8'($urandom);
      end
      if (exp_err) begin
        chk("err_busy", busy, cyc == 1);
        chk("err_flag", error_flag, cyc >= 2);
        chk("err_strobes", {rd_en, wr_en, done}, 0);
      end else begin
        chk("busy", busy, cyc < done_cyc);
        chk("done", done, cyc == done_cyc);
        chk("flag", error_flag, 0);
        if (cyc >= 2) begin
          chk("res_rows", res_rows, exp_rr);
          chk("res_cols", res_cols, exp_rc);
        end
        if (rd_en) begin
          if (ra_q.size() == 0) chk("rd_extra", rd_en, 0);
          else begin
            chk("rd_addr_a", rd_addr_a, ra_q.pop_front());
            chk("rd_addr_b", rd_addr_b, rb_q.pop_front());
          end
        end
        if (wr_en) begin
          if (wd_q.size() == 0) chk("wr_extra", wr_en, 0);
          else begin
            chk("wr_addr", wr_addr, wcnt);
            chk("wr_data", $signed(wr_data), wd_q.pop_front());
            wcnt++;
          end
        end
      end
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        aborted = 1'b1;
      end
    end
    start_op = 1'b0;
    if (aborted) begin
      repeat (2) begin
        @(negedge clk);
        chk_zero("rst_hold");
      end
      rst_n = 1'b1;
      prev_err = 1'b0;
    end else begin
      if (!exp_err) begin
        chk("rd_left", ra_q.size(), 0);
        chk("wr_left", wd_q.size(), 0);
      end
      prev_err = exp_err;
    end
  endtask

  initial begin
    logic [2:0] op, ar, ac, br, bc;
    rst_n = 1'b0; start_op = 1'b0; op_sel = '0; scalar = '0;
    a_rows = '0; a_cols = '0; b_rows = '0; b_cols = '0;
    prev_err = 1'b0;
    for (int n = 0; n < 32; n++) begin mem_a[n] = '0; mem_b[n] = '0; end
    repeat (2) @(negedge clk);
    chk_zero("reset_outs");
    rst_n = 1'b1;

    for (int n = 0; n < 4; n++) begin mem_a[n] = 8'(n+1); mem_b[n] = 8'(n+5); end
    run(3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 8'd0, -1, -1);
    mem_a[0] = 8'sd1; mem_a[1] = -8'sd2; mem_b[0] = 8'sd3; mem_b[1] = 8'sd4;
    run(3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 8'd0, -1, -1);
    run(3'd2, 3'd1, 3'd2, 3'd0, 3'd0, 8'hFD, -1, -1);
    for (int n = 0; n < 6; n++) begin mem_a[n] = 8'(n+1); mem_b[n] = 8'(n+7); end
    run(3'd4, 3'd2, 3'd3, 3'd3, 3'd2, 8'd0, -1, -1);
    run(3'd3, 3'd2, 3'd3, 3'd0, 3'd0, 8'd0, -1, -1);
    run(3'd4, 3'd2, 3'd3, 3'd2, 3'd2, 8'd0, -1, -1);
    run(3'd0, 3'd0, 3'd2, 3'd0, 3'd2, 8'd0, -1, -1);
    run(3'd7, 3'd2, 3'd2, 3'd2, 3'd2, 8'd0, -1, -1);
    for (int n = 0; n < 4; n++) begin mem_a[n] = 8'(n+1); mem_b[n] = 8'(n+5); end
    run(3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 8'd0, 5, -1);
    run(3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 8'd0, 14, -1);
    run(3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 8'd0, -1, 8);
    run(3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 8'd0, -1, -1);

    for (int t = 0; t < 30; t++) begin
      for (int n = 0; n < 32; n++) begin
        mem_a[n] = 8'($urandom_range(0, 255));
        mem_b[n] = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 7) == 0) begin
        op = 3'($urandom); ar = 3'($urandom); ac = 3'($urandom);
        br = 3'($urandom); bc = 3'($urandom);
      end else begin
        op = 3'($urandom_range(0, 4));
        ar = 3'($urandom_range(1, 5));
        ac = 3'($urandom_range(1, 5));
        br = 3'($urandom);
        bc = 3'($urandom_range(1, 5));
        if (op <= 3'd1) begin br = ar; bc = ac; end
        else if (op == 3'd4) br = ac;
      end
      run(op, ar, ac, br, bc, 8'($urandom_range(0, 255)), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
